load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MEM_WORDS, 32, depth in 32-bit words of the attached data memory (word index width = log2(MEM_WORDS) = 5).
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  core request present.
REQ-005 req_ready  out  1  unit can accept a request.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, right-aligned.
REQ-010 resp_valid  out  1  response available.
REQ-011 resp_ready  in  1  core accepts response.
REQ-012 resp_rdata  out  32  extended load data; 0 for stores and faults.
REQ-013 resp_fault  out  1  request faulted; no memory write occurred.
REQ-014 mem_addr  out  5  word index to data memory.
REQ-015 mem_we  out  1  data memory write enable.
REQ-016 mem_wd  out  32  data memory write word.
REQ-017 mem_rd  in  32  data memory read word; combinational from mem_addr.

Function
REQ-018 FSM states: IDLE, MERGE, RESP; req_ready = 1 only in IDLE with reset low.
REQ-019 Accept = req_valid & req_ready; in IDLE, mem_addr = req_addr[6:2]; otherwise mem_addr = the registered word index.
REQ-020 req_addr[31:7] ignored; addresses alias modulo 128 bytes.
REQ-021 Fault conditions: illegal funct3 (load: 011/110/111; store: any value other than 000/001/010); misalignment, per REQ-036.
REQ-022 Faulted accept: no mem_we, resp_rdata = 0, resp_fault = 1, next state RESP.
REQ-023 Load accept: lane selected by addr[1:0] (byte) or addr[1] (half); sign-extend for B/H, zero-extend for BU/HU, pass-through for W; result registered into resp_rdata; next state RESP.
REQ-024 SW accept: mem_we = 1 and mem_wd = req_wdata in the accept cycle; next state RESP.
REQ-025 SB/SH accept: register mem_rd, byte lane(s), funct3 and wdata; next state MERGE; no write in the accept cycle.
REQ-026 MERGE: mem_we = 1; mem_wd = old word with only the addressed byte or half replaced by wdata[7:0] or wdata[15:0]; next state RESP.
REQ-027 RESP: resp_valid = 1; resp_rdata and resp_fault held stable; on resp_ready go to IDLE.
REQ-028 resp_valid and req_ready are never both 1; back-to-back requests are possible, each costing at least one RESP cycle.
REQ-029 Latency, accept to first resp_valid: loads, SW and faults 1 cycle; SB/SH 2 cycles.
REQ-030 mem_we is 0 in every cycle not named in REQ-024/REQ-026.

Reset
REQ-031 During reset: state forced to IDLE, req_ready = 0, mem_we = 0, and no request accepted.
REQ-032 After reset: resp_valid = 0, resp_rdata = 0, resp_fault = 0, and all internal registers are 0.
REQ-033 Reset asserted while in MERGE aborts the merge; memory is unchanged that cycle.
REQ-034 Reset asserted while in RESP drops the pending response without delivering it.

Configuration
REQ-035 Macro LSU_MISALIGN_CHECK_EN selects misalignment handling.
REQ-036 Defined: H/HU/SH with addr[0] = 1, or W/SW with addr[1:0] != 0, fault per REQ-022.
REQ-037 Undefined: misalignment never faults; the ignored low address bits are treated as 0 and the access proceeds.
REQ-038 Illegal funct3 faults in both builds.

Verification
REQ-039 Memory word 3 = 0x8899AABB; LB at addr 0x0D -> resp_rdata = 0xFFFFFFAA, resp_valid 1 cycle after accept.
REQ-040 Same word; LHU at 0x0E -> 0x00008899; LH at 0x0E -> 0xFFFF8899.
REQ-041 Word 2 = 0x11223344; SB wdata 0x000000EE at 0x0A -> MERGE writes 0x11EE3344; resp_valid 2 cycles after accept.
REQ-042 SW 0xDEADBEEF at 0x7C, then LW at 0xFC (aliased address) -> resp_rdata = 0xDEADBEEF.
REQ-043 With macro defined: LW at 0x06 -> resp_fault = 1, resp_rdata = 0; SH at 0x05 -> resp_fault = 1, memory unchanged.
REQ-044 SH accepted, then reset asserted in the MERGE cycle -> mem_we = 0, old word intact, resp_valid = 0, req_ready = 1 on the first cycle after reset deasserts.

Source files
------------

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core request/response and data memory bus of the load/store unit
//
// Ports (signals carried):
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata : core request
//   resp_valid/resp_ready/resp_rdata/resp_fault              : core response
//   mem_addr/mem_we/mem_wd/mem_rd                            : word-wide data memory
// Modports: slave = load/store unit view, master = core + memory environment view.

interface load_store_unit_if #(
    parameter int AW = 5
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_rdata;
    logic          resp_fault;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wd;
    logic [31:0]   mem_rd;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_we, mem_wd
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_we, mem_wd
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RISC-V style byte/half/word load/store unit over a word memory
//
// Ports:
//   clk   : clock, all state on posedge
//   reset : synchronous active-high reset
//   bus   : load_store_unit_if.slave (core request/response + data memory)
// Optional feature: define LSU_MISALIGN_CHECK_EN to fault misaligned H/HU/SH and W/SW
// accesses; without it the low address bits below the access size are ignored.
// Sub-word stores are read-modify-write: the old word is captured in the accept
// cycle and the merged word is written in MERGE.

module load_store_unit #(
    parameter int MEM_WORDS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    load_store_unit_if.slave     bus
);
    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {IDLE, MERGE, RESP} state_t;

    state_t        state;
    logic [AW-1:0] word_idx;
    logic [31:0]   old_word;
    logic [15:0]   wdata_q;
    logic [1:0]    lane_q;
    logic [1:0]    size_q;
    logic [31:0]   rdata_q;
    logic          fault_q;

    logic          accept;
    logic [AW-1:0] req_idx;
    logic [2:0]    f3;
    logic          illegal;
    logic          misalign;
    logic          fault;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_data;
    logic [31:0]   merged;
    logic          unused_addr_bits;

    assign f3               = bus.req_funct3;
    assign req_idx          = bus.req_addr[AW+1:2];
    assign unused_addr_bits = ^bus.req_addr[31:AW+2];

    assign bus.req_ready  = (state == IDLE) && !reset;
    assign accept         = bus.req_valid && bus.req_ready;

    always_comb begin
        illegal = 1'b0;
        if (bus.req_we)
            illegal = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
        else
            illegal = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
                        f3 == 3'b100 || f3 == 3'b101);
    end

`ifdef LSU_MISALIGN_CHECK_EN
    assign misalign = ((f3[1:0] == 2'b01) && bus.req_addr[0]) ||
                      ((f3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign fault = illegal || misalign;

    // Lane selection: half lanes use addr[1] only, so an unchecked odd half
    // address behaves as if addr[0] were 0.
    assign byte_sel = bus.mem_rd[{bus.req_addr[1:0], 3'b000} +: 8];
    assign half_sel = bus.req_addr[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];

    always_comb begin
        load_data = 32'h0;
        case (f3)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_data = bus.mem_rd;
            3'b100:  load_data = {24'h0, byte_sel};
            3'b101:  load_data = {16'h0, half_sel};
            default: load_data = 32'h0;
        endcase
    end

    always_comb begin
        merged = old_word;
        if (size_q == 2'b01) begin
            if (lane_q[1])
                merged[31:16] = wdata_q;
            else
                merged[15:0] = wdata_q;
        end else begin
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    // Full-word stores write straight through in the accept cycle; a merge
    // cut short by reset must not write.
    assign bus.mem_we = (accept && bus.req_we && !fault && f3 == 3'b010) ||
                        (state == MERGE && !reset);
    assign bus.mem_wd = (state == MERGE) ? merged : bus.req_wdata;
    assign bus.mem_addr = (state == IDLE) ? req_idx : word_idx;

    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_fault = fault_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            word_idx <= '0;
            old_word <= 32'h0;
            wdata_q  <= 16'h0;
            lane_q   <= 2'b00;
            size_q   <= 2'b00;
            rdata_q  <= 32'h0;
            fault_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        word_idx <= req_idx;
                        if (fault) begin
                            rdata_q <= 32'h0;
                            fault_q <= 1'b1;
                            state   <= RESP;
                        end else if (!bus.req_we) begin
                            rdata_q <= load_data;
                            fault_q <= 1'b0;
                            state   <= RESP;
                        end else begin
                            rdata_q <= 32'h0;
                            fault_q <= 1'b0;
                            if (f3 == 3'b010) begin
                                state <= RESP;
                            end else begin
                                old_word <= bus.mem_rd;
                                lane_q   <= bus.req_addr[1:0];
                                size_q   <= f3[1:0];
                                wdata_q  <= bus.req_wdata[15:0];
                                state    <= MERGE;
                            end
                        end
                    end
                end
                MERGE: state <= RESP;
                RESP: begin
                    if (bus.resp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a behavioural word memory

module tb_load_store_unit;
    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_fail;
    bit   seen;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];

    logic [31:0] mem [32];

    load_store_unit_if #(.AW(5)) bus ();

    load_store_unit #(.MEM_WORDS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_we)
            mem[bus.mem_addr] <= bus.mem_wd;
    end

    assign bus.mem_rd = mem[bus.mem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.resp_valid) begin
                check("req_ready_during_resp", {31'h0, bus.req_ready}, 32'h0);
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 32'h1, 32'h0);
                end else begin
                    e = exp_q[0];
                    if (!seen) begin
                        check("resp_latency", cyc - e.acc + 1, e.lat);
                        seen = 1'b1;
                    end
                    check("resp_rdata", bus.resp_rdata, e.rdata);
                    check("resp_fault", {31'h0, bus.resp_fault}, {31'h0, e.fault});
                    if (bus.resp_ready) begin
                        void'(exp_q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] er, input logic ef,
                         input int lat, input int hold);
        int t;
        @(posedge clk); #1;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.resp_ready = (hold == 0);
        t = 0;
        while (!bus.req_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (!bus.req_ready) begin
            check("req_ready_timeout", 32'h0, 32'h1);
            bus.req_valid = 1'b0;
            return;
        end
        exp_q.push_back('{er, ef, lat, cyc + 1});
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            bus.resp_ready = 1'b1;
        end
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("resp_timeout", exp_q.size(), 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        seen     = 1'b0;
        reset    = 1'b1;
        // A full-word store held during reset must be ignored.
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h12345678;
        bus.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {31'h0, bus.req_ready}, 32'h0);
        check("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
        check("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        bus.req_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check("rst_resp_fault", {31'h0, bus.resp_fault}, 32'h0);
        check("rst_req_ready_after", {31'h0, bus.req_ready}, 32'h1);

        // Preload through the unit with full-word stores.
        issue(1'b1, 3'b010, 32'h0000000C, 32'h8899AABB, 32'h0, 1'b0, 1, 0);
        issue(1'b1, 3'b010, 32'h00000008, 32'h11223344, 32'h0, 1'b0, 1, 0);
        check("mem3_preload", mem[3], 32'h8899AABB);

        // Loads of every width and extension.
        issue(1'b0, 3'b000, 32'h0000000D, 32'h0, 32'hFFFFFFAA, 1'b0, 1, 0);
        issue(1'b0, 3'b101, 32'h0000000E, 32'h0, 32'h00008899, 1'b0, 1, 0);
        issue(1'b0, 3'b001, 32'h0000000E, 32'h0, 32'hFFFF8899, 1'b0, 1, 0);
        issue(1'b0, 3'b100, 32'h0000000F, 32'h0, 32'h00000088, 1'b0, 1, 0);
        issue(1'b0, 3'b000, 32'h0000000C, 32'h0, 32'hFFFFFFBB, 1'b0, 1, 0);
        issue(1'b0, 3'b010, 32'h0000000C, 32'h0, 32'h8899AABB, 1'b0, 1, 3);

        // Sub-word stores via MERGE.
        issue(1'b1, 3'b000, 32'h0000000A, 32'h000000EE, 32'h0, 1'b0, 2, 0);
        check("mem2_after_sb", mem[2], 32'h11EE3344);
        issue(1'b0, 3'b010, 32'h00000008, 32'h0, 32'h11EE3344, 1'b0, 1, 0);
        issue(1'b1, 3'b001, 32'h0000000A, 32'hFFFF5566, 32'h0, 1'b0, 2, 2);
        check("mem2_after_sh", mem[2], 32'h55663344);

        // Address aliasing modulo 128 bytes.
        issue(1'b1, 3'b010, 32'h0000007C, 32'hDEADBEEF, 32'h0, 1'b0, 1, 0);
        issue(1'b0, 3'b010, 32'h000000FC, 32'h0, 32'hDEADBEEF, 1'b0, 1, 0);

        // Illegal funct3 faults in both builds.
        issue(1'b0, 3'b011, 32'h0000000C, 32'h0, 32'h0, 1'b1, 1, 0);
        issue(1'b0, 3'b111, 32'h0000000C, 32'h0, 32'h0, 1'b1, 1, 0);
        issue(1'b1, 3'b100, 32'h0000007C, 32'h01020304, 32'h0, 1'b1, 1, 0);
        check("mem31_after_bad_store", mem[31], 32'hDEADBEEF);

        // Reset during MERGE aborts the write.
        @(posedge clk); #1;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b001;
        bus.req_addr   = 32'h00000008;
        bus.req_wdata  = 32'h0000BEEF;
        bus.resp_ready = 1'b1;
        check("abort_req_ready", {31'h0, bus.req_ready}, 32'h1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("abort_mem_we", {31'h0, bus.mem_we}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("abort_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        check("abort_req_ready_after", {31'h0, bus.req_ready}, 32'h1);
        check("abort_mem2_intact", mem[2], 32'h55663344);

        // Reset during RESP drops the pending response.
        @(posedge clk); #1;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h0000000C;
        bus.resp_ready = 1'b0;
        exp_q.push_back('{32'h8899AABB, 1'b0, 1, cyc + 1});
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        seen = 1'b0;
        bus.resp_ready = 1'b1;
        #1;
        check("drop_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        check("drop_resp_rdata", bus.resp_rdata, 32'h0);
        issue(1'b0, 3'b100, 32'h0000000E, 32'h0, 32'h00000099, 1'b0, 1, 0);

        // Misaligned accesses.
`ifdef LSU_MISALIGN_CHECK_EN
        issue(1'b0, 3'b010, 32'h0000000E, 32'h0, 32'h0, 1'b1, 1, 0);
        issue(1'b0, 3'b001, 32'h0000000D, 32'h0, 32'h0, 1'b1, 1, 0);
        issue(1'b0, 3'b010, 32'h00000006, 32'h0, 32'h0, 1'b1, 1, 0);
        issue(1'b1, 3'b001, 32'h00000009, 32'h0000CAFE, 32'h0, 1'b1, 1, 0);
        check("mem2_after_misaligned_sh", mem[2], 32'h55663344);
`else
        issue(1'b0, 3'b010, 32'h0000000E, 32'h0, 32'h8899AABB, 1'b0, 1, 0);
        issue(1'b0, 3'b001, 32'h0000000D, 32'h0, 32'hFFFFAABB, 1'b0, 1, 0);
        issue(1'b1, 3'b001, 32'h00000009, 32'h0000CAFE, 32'h0, 1'b0, 2, 0);
        check("mem2_after_misaligned_sh", mem[2], 32'h5566CAFE);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
